// File: rtl/nubus_slave.sv
// -----------------------------------------------------------------------------
// nubus_slave
//
// NuBus slave front end that turns a selected NuBus transfer into a single
// request on a simple valid/ready memory port, then returns a one-cycle
// acknowledge (with read data for reads) to the bus.
//
// Transfer flow: IDLE -> (write) WDATA -> MEM -> ACK -> IDLE
//                IDLE -> (read)          MEM -> ACK -> IDLE
// Every output comes straight from a flop; nothing on nub_* or mem_ready
// reaches an output combinationally.
//
// Optional feature: define NUBUS_SLAVE_TIMEOUT_EN to add a MEM-phase watchdog.
// After TIMEOUT_CLOCKS cycles in MEM without mem_ready the transfer is
// acknowledged with error status nub_tm_o = 2'b01. Without the macro the slave
// waits in MEM indefinitely and nub_tm_o is always 2'b00.
//
// Parameters
//   TIMEOUT_CLOCKS : MEM cycles before error acknowledge (1..255, watchdog only)
//
// Ports
//   mem_clk     in   clock, all state changes on the rising edge
//   mem_reset   in   asynchronous active-high reset
//   nub_start   in   address-phase strobe (already synchronous to mem_clk)
//   nub_tm      in   [1] 1=read 0=write, [0] 1=word 0=byte
//   nub_ad_i    in   address in START cycle, write data in the next cycle
//   nub_id      in   this card's slot number
//   nub_ad_o    out  read data to the bus (holds last captured read data)
//   nub_ad_oe   out  drive enable for nub_ad_o (read ACK only)
//   nub_ack     out  one-cycle transfer acknowledge
//   nub_tm_o    out  acknowledge status: 00 ok, 01 timeout
//   mem_valid   out  memory request, high exactly while in MEM
//   mem_wstrb   out  byte write strobes (0000 for reads)
//   mem_addr    out  latched NuBus address
//   mem_wdata   out  latched write data
//   mem_myslot  out  address hit the slot space Fs000000
//   mem_myexp   out  address hit the super-slot space s0000000
//   mem_rdata   in   memory read data
//   mem_ready   in   memory acknowledge
// -----------------------------------------------------------------------------
module nubus_slave #(
    parameter int unsigned TIMEOUT_CLOCKS = 255
) (
    input  logic        mem_clk,
    input  logic        mem_reset,
    input  logic        nub_start,
    input  logic [1:0]  nub_tm,
    input  logic [31:0] nub_ad_i,
    input  logic [3:0]  nub_id,
    output logic [31:0] nub_ad_o,
    output logic        nub_ad_oe,
    output logic        nub_ack,
    output logic [1:0]  nub_tm_o,
    output logic        mem_valid,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_myslot,
    output logic        mem_myexp,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WDATA = 2'd1,
        ST_MEM   = 2'd2,
        ST_ACK   = 2'd3
    } state_t;

    // Byte strobes for a request: none for reads, all for word writes,
    // otherwise the single lane addressed by the low two address bits.
    function automatic logic [3:0] wstrb_decode(input logic [1:0] tm,
                                                input logic [1:0] lane);
        logic [3:0] strb;
        if (tm[1]) begin
            strb = 4'b0000;
        end else if (tm[0]) begin
            strb = 4'b1111;
        end else begin
            strb = 4'b0001 << lane;
        end
        return strb;
    endfunction

    state_t      state_q,  state_d;
    logic [31:0] addr_q,   addr_d;
    logic        read_q,   read_d;
    logic [3:0]  wstrb_q,  wstrb_d;
    logic        myslot_q, myslot_d;
    logic        myexp_q,  myexp_d;
    logic [31:0] wdata_q,  wdata_d;
    logic [31:0] rdata_q,  rdata_d;
    logic        valid_q,  valid_d;
    logic        ack_q,    ack_d;
    logic        oe_q,     oe_d;
    logic [1:0]  tm_o_q,   tm_o_d;

    logic        myslot_s;
    logic        myexp_s;

`ifdef NUBUS_SLAVE_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT_CLOCKS);
    logic [7:0]  cnt_q, cnt_d;
`endif

    // Card select decode on the live address-phase bus.
    always_comb begin
        myslot_s = (nub_ad_i[31:28] == 4'hF) && (nub_ad_i[27:24] == nub_id);
        myexp_s  = (nub_ad_i[31:28] == nub_id);
    end

    // Next-state and next-output logic for the transfer sequencer.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        read_d   = read_q;
        wstrb_d  = wstrb_q;
        myslot_d = myslot_q;
        myexp_d  = myexp_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        valid_d  = 1'b0;
        ack_d    = 1'b0;
        oe_d     = 1'b0;
        tm_o_d   = 2'b00;
`ifdef NUBUS_SLAVE_TIMEOUT_EN
        cnt_d    = cnt_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (nub_start && (myslot_s || myexp_s)) begin
                    addr_d   = nub_ad_i;
                    read_d   = nub_tm[1];
                    wstrb_d  = wstrb_decode(nub_tm, nub_ad_i[1:0]);
                    myslot_d = myslot_s;
                    myexp_d  = myexp_s;
                    if (nub_tm[1]) begin
                        state_d = ST_MEM;
                        valid_d = 1'b1;
`ifdef NUBUS_SLAVE_TIMEOUT_EN
                        cnt_d   = 8'd0;
`endif
                    end else begin
                        state_d = ST_WDATA;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_WDATA: begin
                wdata_d = nub_ad_i;
                state_d = ST_MEM;
                valid_d = 1'b1;
`ifdef NUBUS_SLAVE_TIMEOUT_EN
                cnt_d   = 8'd0;
`endif
            end

            ST_MEM: begin
                // A ready in the same cycle the limit is hit still wins.
                if (mem_ready) begin
                    if (read_q) begin
                        rdata_d = mem_rdata;
                    end else begin
                        rdata_d = rdata_q;
                    end
                    state_d = ST_ACK;
                    ack_d   = 1'b1;
                    oe_d    = read_q;
                    tm_o_d  = 2'b00;
                end else begin
`ifdef NUBUS_SLAVE_TIMEOUT_EN
                    if ((cnt_q + 8'd1) == TIMEOUT_LIM) begin
                        state_d = ST_ACK;
                        ack_d   = 1'b1;
                        tm_o_d  = 2'b01;
                        cnt_d   = cnt_q + 8'd1;
                    end else begin
                        cnt_d   = cnt_q + 8'd1;
                        valid_d = 1'b1;
                    end
`else
                    valid_d = 1'b1;
`endif
                end
            end

            ST_ACK: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any transfer without an ack.
    always_ff @(posedge mem_clk or posedge mem_reset) begin
        if (mem_reset) begin
            state_q  <= ST_IDLE;
            addr_q   <= 32'd0;
            read_q   <= 1'b0;
            wstrb_q  <= 4'd0;
            myslot_q <= 1'b0;
            myexp_q  <= 1'b0;
            wdata_q  <= 32'd0;
            rdata_q  <= 32'd0;
            valid_q  <= 1'b0;
            ack_q    <= 1'b0;
            oe_q     <= 1'b0;
            tm_o_q   <= 2'b00;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            read_q   <= read_d;
            wstrb_q  <= wstrb_d;
            myslot_q <= myslot_d;
            myexp_q  <= myexp_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            valid_q  <= valid_d;
            ack_q    <= ack_d;
            oe_q     <= oe_d;
            tm_o_q   <= tm_o_d;
        end
    end

`ifdef NUBUS_SLAVE_TIMEOUT_EN
    // MEM-phase watchdog counter.
    always_ff @(posedge mem_clk or posedge mem_reset) begin
        if (mem_reset) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    assign nub_ad_o   = rdata_q;
    assign nub_ad_oe  = oe_q;
    assign nub_ack    = ack_q;
    assign nub_tm_o   = tm_o_q;
    assign mem_valid  = valid_q;
    assign mem_wstrb  = wstrb_q;
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;
    assign mem_myslot = myslot_q;
    assign mem_myexp  = myexp_q;

endmodule

// File: tb/tb_nubus_slave.sv
module tb_nubus_slave;

    logic        mem_clk;
    logic        mem_reset;
    logic        nub_start;
    logic [1:0]  nub_tm;
    logic [31:0] nub_ad_i;
    logic [3:0]  nub_id;
    logic [31:0] nub_ad_o;
    logic        nub_ad_oe;
    logic        nub_ack;
    logic [1:0]  nub_tm_o;
    logic        mem_valid;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_myslot;
    logic        mem_myexp;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        ready_en;

    int nvec = 0;
    int nerr = 0;

    // Zero-wait memory when ready_en is high; ready_en low inserts wait states.
    assign mem_ready = mem_valid & ready_en;

    nubus_slave #(.TIMEOUT_CLOCKS(4)) dut (
        .mem_clk    (mem_clk),
        .mem_reset  (mem_reset),
        .nub_start  (nub_start),
        .nub_tm     (nub_tm),
        .nub_ad_i   (nub_ad_i),
        .nub_id     (nub_id),
        .nub_ad_o   (nub_ad_o),
        .nub_ad_oe  (nub_ad_oe),
        .nub_ack    (nub_ack),
        .nub_tm_o   (nub_tm_o),
        .mem_valid  (mem_valid),
        .mem_wstrb  (mem_wstrb),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_myslot (mem_myslot),
        .mem_myexp  (mem_myexp),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready)
    );

    initial mem_clk = 1'b0;
    always #5 mem_clk = ~mem_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, 32'(mem_valid), 32'd0);
        chk({tag, "_ack"},   32'(nub_ack),   32'd0);
        chk({tag, "_oe"},    32'(nub_ad_oe), 32'd0);
        chk({tag, "_tmo"},   32'(nub_tm_o),  32'd0);
        chk({tag, "_addr"},  mem_addr,       32'd0);
        chk({tag, "_wstrb"}, 32'(mem_wstrb), 32'd0);
        chk({tag, "_wdata"}, mem_wdata,      32'd0);
        chk({tag, "_ado"},   nub_ad_o,       32'd0);
        chk({tag, "_slot"},  32'(mem_myslot), 32'd0);
        chk({tag, "_exp"},   32'(mem_myexp), 32'd0);
    endtask

    // Word read with zero-wait memory: valid at T+1, ack at T+2.
    task automatic do_read(input logic [31:0] addr, input logic [31:0] data,
                           input logic exp_slot, input logic exp_exp);
        @(negedge mem_clk);
        nub_start = 1'b1; nub_tm = 2'b11; nub_ad_i = addr; mem_rdata = data;
        @(negedge mem_clk);
        nub_start = 1'b0; nub_ad_i = 32'd0;
        chk("rd_valid",   32'(mem_valid),  32'd1);
        chk("rd_addr",    mem_addr,        addr);
        chk("rd_wstrb",   32'(mem_wstrb),  32'd0);
        chk("rd_slot",    32'(mem_myslot), 32'(exp_slot));
        chk("rd_exp",     32'(mem_myexp),  32'(exp_exp));
        chk("rd_noack",   32'(nub_ack),    32'd0);
        @(negedge mem_clk);
        chk("rd_ack",     32'(nub_ack),    32'd1);
        chk("rd_oe",      32'(nub_ad_oe),  32'd1);
        chk("rd_data",    nub_ad_o,        data);
        chk("rd_tmo",     32'(nub_tm_o),   32'd0);
        chk("rd_vdrop",   32'(mem_valid),  32'd0);
        @(negedge mem_clk);
        chk("rd_ack1",    32'(nub_ack),    32'd0);
        chk("rd_oe1",     32'(nub_ad_oe),  32'd0);
        chk("rd_hold",    nub_ad_o,        data);
    endtask

    // Write: data phase at T+1, valid at T+2, ack at T+3.
    task automatic do_write(input logic [31:0] addr, input logic [1:0] tm,
                            input logic [31:0] data, input logic [3:0] exp_strb,
                            input logic exp_slot, input logic exp_exp,
                            input logic [31:0] exp_ado);
        @(negedge mem_clk);
        nub_start = 1'b1; nub_tm = tm; nub_ad_i = addr;
        @(negedge mem_clk);
        nub_start = 1'b0; nub_ad_i = data;
        chk("wr_novalid", 32'(mem_valid),  32'd0);
        chk("wr_noack",   32'(nub_ack),    32'd0);
        @(negedge mem_clk);
        nub_ad_i = 32'd0;
        chk("wr_valid",   32'(mem_valid),  32'd1);
        chk("wr_addr",    mem_addr,        addr);
        chk("wr_wstrb",   32'(mem_wstrb),  32'(exp_strb));
        chk("wr_wdata",   mem_wdata,       data);
        chk("wr_slot",    32'(mem_myslot), 32'(exp_slot));
        chk("wr_exp",     32'(mem_myexp),  32'(exp_exp));
        chk("wr_noack2",  32'(nub_ack),    32'd0);
        @(negedge mem_clk);
        chk("wr_ack",     32'(nub_ack),    32'd1);
        chk("wr_oe",      32'(nub_ad_oe),  32'd0);
        chk("wr_tmo",     32'(nub_tm_o),   32'd0);
        chk("wr_vdrop",   32'(mem_valid),  32'd0);
        chk("wr_adohold", nub_ad_o,        exp_ado);
        @(negedge mem_clk);
        chk("wr_ack1",    32'(nub_ack),    32'd0);
    endtask

    initial begin
        int valid_cnt;
        int ack_cnt;
        int ack_at;

        mem_reset = 1'b1;
        nub_start = 1'b0;
        nub_tm    = 2'b00;
        nub_ad_i  = 32'd0;
        nub_id    = 4'h9;
        mem_rdata = 32'd0;
        ready_en  = 1'b1;
        repeat (3) @(negedge mem_clk);
        chk_all_zero("rst");
        mem_reset = 1'b0;
        @(negedge mem_clk);
        chk_all_zero("idle");

        // Slot-space word read.
        do_read(32'hF900_0010, 32'hDEAD_BEEF, 1'b1, 1'b0);

        // Writes: byte lanes 3,1,2 and a word write.
        do_write(32'h9000_0003, 2'b00, 32'h0000_00A5, 4'b1000, 1'b0, 1'b1, 32'hDEAD_BEEF);
        do_write(32'hF900_0101, 2'b00, 32'h0000_5A00, 4'b0010, 1'b1, 1'b0, 32'hDEAD_BEEF);
        do_write(32'h9000_0008, 2'b01, 32'h1234_5678, 4'b1111, 1'b0, 1'b1, 32'hDEAD_BEEF);
        do_write(32'hF900_0002, 2'b00, 32'h0033_0000, 4'b0100, 1'b1, 1'b0, 32'hDEAD_BEEF);

        // Unselected START is ignored.
        valid_cnt = 0; ack_cnt = 0;
        @(negedge mem_clk);
        nub_start = 1'b1; nub_tm = 2'b11; nub_ad_i = 32'hFA00_0000;
        for (int i = 0; i < 8; i++) begin
            @(negedge mem_clk);
            nub_start = 1'b0;
            if (mem_valid) valid_cnt++;
            if (nub_ack) ack_cnt++;
        end
        chk("unsel_valid", 32'(valid_cnt), 32'd0);
        chk("unsel_ack",   32'(ack_cnt),   32'd0);

        // Three wait clocks, with a second START during MEM.
        valid_cnt = 0; ack_cnt = 0; ack_at = 0;
        ready_en = 1'b0;
        @(negedge mem_clk);
        nub_start = 1'b1; nub_tm = 2'b11; nub_ad_i = 32'h9000_0020; mem_rdata = 32'hCAFE_F00D;
        for (int i = 1; i <= 12; i++) begin
            @(negedge mem_clk);
            if (mem_valid) valid_cnt++;
            if (nub_ack) begin
                ack_cnt++;
                ack_at = i;
            end
            if (i == 1) begin
                nub_start = 1'b1; nub_tm = 2'b01; nub_ad_i = 32'h9000_0040;
            end else if (i == 2) begin
                nub_start = 1'b0; nub_ad_i = 32'd0;
            end
            if (i == 4) ready_en = 1'b1;
        end
        chk("wait_valid_cycles", 32'(valid_cnt), 32'd4);
        chk("wait_ack_count",    32'(ack_cnt),   32'd1);
        chk("wait_ack_cycle",    32'(ack_at),    32'd5);
        chk("wait_rdata",        nub_ad_o,       32'hCAFE_F00D);
        chk("wait_addr",         mem_addr,       32'h9000_0020);

        // Reset in MEM clears outputs at once; no ack afterwards.
        ready_en = 1'b0;
        @(negedge mem_clk);
        nub_start = 1'b1; nub_tm = 2'b11; nub_ad_i = 32'h9000_0050; mem_rdata = 32'h1111_2222;
        @(negedge mem_clk);
        nub_start = 1'b0; nub_ad_i = 32'd0;
        chk("pre_rst_valid", 32'(mem_valid), 32'd1);
        #2 mem_reset = 1'b1;
        #1;
        chk_all_zero("async_rst");
        @(negedge mem_clk);
        mem_reset = 1'b0;
        ready_en  = 1'b1;
        ack_cnt = 0; valid_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge mem_clk);
            if (nub_ack) ack_cnt++;
            if (mem_valid) valid_cnt++;
        end
        chk("post_rst_ack",   32'(ack_cnt),   32'd0);
        chk("post_rst_valid", 32'(valid_cnt), 32'd0);
        do_read(32'h9000_0060, 32'h0BAD_CAFE, 1'b0, 1'b1);

        // MEM with no memory response.
        ready_en = 1'b0;
        valid_cnt = 0; ack_cnt = 0; ack_at = 0;
        @(negedge mem_clk);
        nub_start = 1'b1; nub_tm = 2'b11; nub_ad_i = 32'hF900_0070; mem_rdata = 32'h5555_AAAA;
`ifdef NUBUS_SLAVE_TIMEOUT_EN
        for (int i = 1; i <= 8; i++) begin
            @(negedge mem_clk);
            nub_start = 1'b0;
            if (mem_valid) valid_cnt++;
            if (nub_ack) begin
                ack_cnt++;
                ack_at = i;
                chk("to_tmo", 32'(nub_tm_o),  32'd1);
                chk("to_oe",  32'(nub_ad_oe), 32'd0);
                chk("to_vdrop", 32'(mem_valid), 32'd0);
            end
        end
        chk("to_valid_cycles", 32'(valid_cnt), 32'd4);
        chk("to_ack_count",    32'(ack_cnt),   32'd1);
        chk("to_ack_cycle",    32'(ack_at),    32'd5);
        chk("to_ado_hold",     nub_ad_o,       32'h0BAD_CAFE);
        ready_en = 1'b1;
`else
        for (int i = 1; i <= 300; i++) begin
            @(negedge mem_clk);
            nub_start = 1'b0;
            if (mem_valid) valid_cnt++;
            if (nub_ack) ack_cnt++;
            if (nub_tm_o != 2'b00) ack_at++;
        end
        chk("nowd_valid_cycles", 32'(valid_cnt), 32'd300);
        chk("nowd_ack_count",    32'(ack_cnt),   32'd0);
        chk("nowd_tmo",          32'(ack_at),    32'd0);
        ready_en = 1'b1;
        @(negedge mem_clk);
        chk("nowd_ack",  32'(nub_ack),  32'd1);
        chk("nowd_data", nub_ad_o,      32'h5555_AAAA);
        chk("nowd_tmo2", 32'(nub_tm_o), 32'd0);
`endif
        repeat (2) @(negedge mem_clk);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/nubus_slave.md
NUBUS_SLAVE -- requirements
Module: nubus_slave

Interface
REQ-001 Parameter: TIMEOUT_CLOCKS, 255, max mem_clk cycles in MEM before error acknowledge (used only with NUBUS_SLAVE_TIMEOUT_EN; legal 1..255).
REQ-002 mem_clk  in  1  single clock; all state changes on rising edge.
REQ-003 mem_reset  in  1  asynchronous, active-high reset.
REQ-004 nub_start  in  1  address-phase strobe, active-high, already synchronised to mem_clk.
REQ-005 nub_tm  in  2  transfer mode: [1]=1 read, 0 write; [0]=1 word, 0 byte.
REQ-006 nub_ad_i  in  32  address in START cycle, write data in following cycle.
REQ-007 nub_id  in  4  this card's slot number.
REQ-008 nub_ad_o  out  32  read data to bus.
REQ-009 nub_ad_oe  out  1  drive enable for nub_ad_o.
REQ-010 nub_ack  out  1  one-cycle transfer acknowledge.
REQ-011 nub_tm_o  out  2  status with nub_ack: 00 ok, 01 timeout error.
REQ-012 mem_valid, mem_wstrb[3:0], mem_addr[31:0], mem_wdata[31:0], mem_myslot, mem_myexp  out  memory request, same meaning as the memory port.
REQ-013 mem_rdata  in  32  memory read data; mem_ready  in  1  memory acknowledge.

Function
REQ-014 States: IDLE, WDATA, MEM, ACK; all outputs decoded from registers, no combinational path from nub_* or mem_ready to any output.
REQ-015 Select: myslot = ad[31:28]==4'hF and ad[27:24]==nub_id; myexp = ad[31:28]==nub_id; selected = myslot or myexp.
REQ-016 IDLE: nub_start and selected -> latch address, tm, myslot, myexp; write -> WDATA, read -> MEM; unselected START ignored.
REQ-017 WDATA: capture nub_ad_i into mem_wdata, -> MEM (exactly one cycle).
REQ-018 mem_wstrb: read 0000; word write 1111; byte write 1 shifted left by latched ad[1:0].
REQ-019 mem_addr = latched address unmodified; mem_valid = 1 exactly while in MEM.
REQ-020 MEM: mem_ready=1 -> capture mem_rdata (reads), -> ACK; mem_valid falls the next cycle.
REQ-021 ACK: nub_ack=1 for exactly one cycle; reads also nub_ad_oe=1 with captured data; -> IDLE.
REQ-022 Latency, zero-wait memory: read START cycle T, mem_valid T+1, nub_ack T+2; write mem_valid T+2, nub_ack T+3.
REQ-023 nub_start outside IDLE is ignored; no queuing.
REQ-024 nub_ad_oe = 0 in all states except read ACK; nub_ad_o holds last captured data.

Reset
REQ-025 mem_reset forces IDLE immediately, including mid-transfer; no ack is issued for the aborted transfer.
REQ-026 Reset values: all outputs 0, captured address/data/rdata 0, timeout counter 0.

Configuration
REQ-027 Macro NUBUS_SLAVE_TIMEOUT_EN defined: counter clears on MEM entry, increments each MEM cycle without mem_ready; reaching TIMEOUT_CLOCKS -> ACK with nub_tm_o=01, nub_ad_oe=0.
REQ-028 Macro undefined: no counter, MEM waits indefinitely, nub_tm_o constant 00.
REQ-029 mem_ready in the same cycle the limit is reached takes priority: status 00.

Verification
REQ-030 nub_id=4'h9, START, read word ad=32'hF9000010, mem_ready=mem_valid, rdata=32'hDEADBEEF -> mem_addr=32'hF9000010, wstrb 0000, nub_ack at T+2 with nub_ad_o=32'hDEADBEEF, oe=1, tm_o=00.
REQ-031 Byte write ad=32'h90000003, next-cycle data 32'h000000A5 -> mem_wstrb=1000, mem_myexp=1, mem_myslot=0, ack at T+3, oe=0.
REQ-032 START with ad=32'hFA000000, nub_id=9 -> no mem_valid, no ack ever.
REQ-033 Memory with 3 wait clocks -> mem_valid high 4 cycles, single ack, second START during MEM ignored.
REQ-034 Reset asserted in MEM -> all outputs 0 asynchronously, no ack after release; next transfer completes normally.
REQ-035 With NUBUS_SLAVE_TIMEOUT_EN, TIMEOUT_CLOCKS=4, mem_ready tied 0 -> ack after 4 MEM cycles, nub_tm_o=01, mem_valid drops.
